// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, GF(2^8) doubling, key-length lookups and the
// key-schedule state encoding.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StHold
  } ks_state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int unsigned nk_of(input int unsigned key_bits);
    return key_bits / 32;
  endfunction

  function automatic int unsigned nr_of(input int unsigned key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/key_schedule_iter_if.sv
// Start/key request plus round-key valid/ready stream of the iterative key schedule.
interface key_schedule_iter_if #(
  parameter int unsigned KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                ready;
  logic                rk_valid;
  logic                rk_ready;
  logic [127:0]        rk_data;
  logic [3:0]          rk_idx;
  logic                done;

  modport master (
    output start, key_in, rk_ready,
    input  ready, rk_valid, rk_data, rk_idx, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output ready, rk_valid, rk_data, rk_idx, done
  );
endinterface

// File: rtl/aes_sbox.sv
// Byte S-box: multiplicative inverse in GF(2^8) followed by the AES affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign out_byte = affine(gf_inv(in_byte));

endmodule

// File: rtl/sub_word.sv
// SubWord: four parallel byte S-box lookups on a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  word_t in_word,
  output word_t out_word
);

  for (genvar b = 0; b < 4; b++) begin : gen_sbox
    aes_sbox u_sbox (
      .in_byte  (in_word[8*b +: 8]),
      .out_byte (out_word[8*b +: 8])
    );
  end

endmodule

// File: rtl/key_schedule_iter.sv
// Iterative AES key schedule: latches a 128/192/256-bit key and streams the Nr+1 round keys,
// one schedule word per clock, with generation stalled while a round key waits for its consumer.
module key_schedule_iter
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input logic                clk,
  input logic                rst_n,
  key_schedule_iter_if.slave ks
);

  localparam int unsigned Nk     = nk_of(KEY_BITS);
  localparam int unsigned Nr     = nr_of(KEY_BITS);
  localparam logic [5:0]  NkW    = 6'(Nk);
  localparam logic [3:0]  NrW    = 4'(Nr);
  localparam logic [2:0]  PhLast = 3'(Nk - 1);
  localparam bit          MidSub = (Nk == 8);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gen_bad_key_bits
    $error("key_schedule_iter: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_e    st_q;
  word_t        win_q [Nk];  // w[i-Nk] at index 0 .. w[i-1] at index Nk-1
  logic [95:0]  asm_q;
  logic [5:0]   idx_q;
  logic [2:0]   ph_q;
  logic [7:0]   rcon_q;
  logic         rk_valid_q;
  logic [127:0] rk_data_q;
  logic [3:0]   rk_idx_q;

  word_t key_w [Nk];
  word_t prev_w;
  word_t sub_in;
  word_t sub_out;
  word_t f_w;
  word_t new_w;
  logic  step;
  logic  last_key;

  always_comb begin
    for (int unsigned j = 0; j < Nk; j++) begin
      key_w[j] = ks.key_in[KEY_BITS-1-32*j -: 32];
    end
  end

  sub_word u_sub_word (
    .in_word  (sub_in),
    .out_word (sub_out)
  );

  always_comb begin
    prev_w = win_q[Nk-1];
    sub_in = (ph_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    f_w    = prev_w;
    if (ph_q == 3'd0) begin
      f_w = sub_out ^ {rcon_q, 24'h000000};
    end else if (MidSub && ph_q == 3'd4) begin
      f_w = sub_out;
    end
    new_w = (idx_q < NkW) ? win_q[0] : (win_q[0] ^ f_w);
  end

  assign last_key = (rk_idx_q == NrW);
  // The handshake edge itself produces the next word, so no cycle is lost between keys.
  assign step     = (st_q == StGen) || (st_q == StHold && ks.rk_ready && !last_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= StIdle;
      for (int unsigned j = 0; j < Nk; j++) win_q[j] <= '0;
      asm_q      <= '0;
      idx_q      <= '0;
      ph_q       <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (ks.start) begin
            // Word 0 is emitted on the accepting edge; the window is preloaded rotated by one.
            for (int unsigned j = 0; j + 1 < Nk; j++) win_q[j] <= key_w[j+1];
            win_q[Nk-1] <= key_w[0];
            asm_q       <= {64'h0, key_w[0]};
            idx_q       <= 6'd1;
            ph_q        <= 3'd1;
            rcon_q      <= 8'h01;
            st_q        <= StGen;
          end
        end
        StGen: begin
          if (idx_q[1:0] == 2'd3) begin
            rk_data_q  <= {asm_q, new_w};
            rk_valid_q <= 1'b1;
            rk_idx_q   <= idx_q[5:2];
            st_q       <= StHold;
          end
        end
        StHold: begin
          if (ks.rk_ready) begin
            rk_valid_q <= 1'b0;
            st_q       <= last_key ? StIdle : StGen;
          end
        end
        default: st_q <= StIdle;
      endcase

      if (step) begin
        for (int unsigned j = 0; j + 1 < Nk; j++) win_q[j] <= win_q[j+1];
        win_q[Nk-1] <= new_w;
        asm_q       <= {asm_q[63:0], new_w};
        idx_q       <= idx_q + 6'd1;
        ph_q        <= (ph_q == PhLast) ? 3'd0 : ph_q + 3'd1;
        if (idx_q >= NkW && ph_q == 3'd0) rcon_q <= xtime(rcon_q);
      end
    end
  end

  assign ks.ready    = (st_q == StIdle);
  assign ks.rk_valid = rk_valid_q;
  assign ks.rk_data  = rk_data_q;
  assign ks.rk_idx   = rk_idx_q;
  assign ks.done     = rk_valid_q && ks.rk_ready && last_key;

endmodule

// File: doc/key_schedule_iter.md
# key_schedule_iter

Iterative, parametrised AES key schedule: on `start` it latches a 128/192/256-bit cipher key and streams all Nr+1 round keys, one 128-bit key per `rk_valid`/`rk_ready` handshake, computing one schedule word per clock. It replaces the single-step combinational round-key generator in the AES datapath. It feeds the round controller or a round-key buffer in order: round 0 first, round Nr last.

## Interface
- `KEY_BITS`, default 128: key length, legal values 128/192/256. Nk = KEY_BITS/32; Nr = 10/12/14. Illegal values are an elaboration error.
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin schedule; accepted only when `ready`=1
- `key_in`  in  KEY_BITS  cipher key, MSB = first byte; sampled on the accepted `start`
- `ready`  out  1  idle, can accept `start`
- `rk_valid`  out  1  `rk_data` holds a round key
- `rk_ready`  in  1  consumer accepts `rk_data`
- `rk_data`  out  128  round key, word w[4k] in bits [127:96]
- `rk_idx`  out  4  round number k of `rk_data`
- `done`  out  1  one-cycle pulse on the handshake of round key Nr

## Operation
- States: IDLE, GEN, HOLD. Reset and return state: IDLE.
- IDLE: `ready`=1. On `start`, latch `key_in` into an Nk-word window, clear word index i and phase p (= i mod Nk), set rcon=0x01, then go to GEN. `start` is ignored outside IDLE.
- GEN: produce one word w[i] per cycle and append it to the 4-word assembly register.
  - For i<Nk: w[i] = key word i.
  - For i≥Nk: w[i] = w[i−Nk] ^ f(w[i−1]).
    - p==0: f = SubWord(RotWord(x)) ^ {rcon,24'h0}, then rcon ← xtime(rcon). xtime is a left shift, XOR 0x1b on carry-out.
    - Nk==8 and p==4: f = SubWord(x).
    - Otherwise: f = x.
  - Shift the window after each word. Increment i, and increment p modulo Nk.
- On the 4th word of a group, load `rk_data`, set `rk_valid`, set `rk_idx`=i/4, then go to HOLD.
- HOLD: generation stalls while `rk_valid`=1 and `rk_ready`=0. On the handshake:
  - If `rk_idx`==Nr: pulse `done` and go to IDLE.
  - Otherwise go to GEN in the same edge, so generation resumes next cycle.
- Total words per run: 4(Nr+1), i.e. 44, 52 or 60.
- `rk_data`/`rk_idx` are stable while `rk_valid`=1 and `rk_ready`=0.
- Reset mid-run: all state is cleared immediately.
  - `rk_valid`, `done` and `rk_data` go to 0, `rk_idx` goes to 0, `ready` goes to 1.
  - The partial schedule is discarded.

## Timing
- Reset values: `ready`=1, `rk_valid`=0, `rk_data`=0, `rk_idx`=0, `done`=0.
- `start` accepted at edge 0. With `rk_ready` held 1, round key k is valid in cycle 4k+4 and accepted at edge 4k+4.
- Each stalled cycle in HOLD delays all later keys by one cycle.
- AES-128: 44 cycles start-to-done with no stalls. AES-192: 52. AES-256: 60.
- `done` and the final `rk_valid` coincide. `ready` rises the cycle after.
- `start` asserted in the `done` cycle is ignored. The earliest new `start` is the following cycle.
- SubWord path: four parallel S-box lookups, combinational within one cycle. There is no pipelining across words.

## Structure
- Shared package `aes_pkg`:
  - word type (32 bits)
  - `xtime` function
  - Nk/Nr lookup functions of KEY_BITS
  - state enum
- Sub-module `sub_word`: a 32-bit in/out wrapper around four instances of the team's existing byte S-box. It is instantiated once.
- The window is a Nk-deep word shift register sized for KEY_BITS.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 -> rk0 = key, rk1 = a0fafe1788542cb123a339392a6c7605, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at cycle 44 with `done`.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk1 = 62f8ead2522c6b7bfe0c91f72402f5a5; 13 keys total, `done` at cycle 52.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk2 = 9ba354118e6925afa51a8b5f2067fcde (exercises p==4 SubWord), rk14 = fe4890d1e6188d0b046df344706c631e at cycle 60.
- Backpressure: AES-128 with `rk_ready` random 50% -> same 11 keys in order; `rk_data`/`rk_idx` stable whenever `rk_valid`=1 and `rk_ready`=0; no extra or missing handshakes.
- `start` pulsed while busy with a different key -> ignored; output sequence unchanged.
- `rst_n` asserted after rk3 -> outputs at reset values asynchronously; a new `start` after release yields a correct, complete schedule from rk0.
